bus_arbiter_mux: RTL and testbench

Parametrised, registered bus source selector for the datapath bus. It replaces the fixed 32-input select mux with an N-source, WIDTH-bit block that has two modes. DIRECT mode is the legacy control-unit select. ROUND_ROBIN mode is request/grant arbitration with bounded bus locking. The block sits between the register file, special registers and memory data paths on one side and the shared bus on the other, and drives the bus one cycle after selection.

---
 rtl/bus_pkg.sv | 19 +
 rtl/bus_arbiter_mux_if.sv | 36 +++
 rtl/bus_arbiter_mux_rr_pick.sv | 42 ++++
 rtl/bus_arbiter_mux.sv | 154 +++++++++++++++
 tb/tb_bus_arbiter_mux.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared types and default sizing for the datapath bus source selector.
package bus_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  // Defaults shared with the datapath top.
  localparam int BUS_WIDTH    = 32;
  localparam int BUS_N_SRC    = 32;
  localparam int BUS_MAX_LOCK = 16;

endpackage

// File: rtl/bus_arbiter_mux_if.sv
// Bus-side signal bundle of the source selector: control/requests in, bus out.
interface bus_arbiter_mux_if
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int N_SRC = BUS_N_SRC
);
  localparam int SEL_W = $clog2(N_SRC);

  logic                   mode;
  logic [SEL_W-1:0]       sel;
  logic                   sel_en;
  logic [N_SRC-1:0]       req;
  logic [N_SRC-1:0]       lock;
  logic [N_SRC*WIDTH-1:0] data_in;

  logic [WIDTH-1:0]       bus_out;
  logic                   bus_valid;
  logic [N_SRC-1:0]       grant;
  logic [SEL_W-1:0]       grant_idx;
  logic                   sel_err;
  logic                   lock_timeout;

  // Control unit / sources side.
  modport master (
    output mode, sel, sel_en, req, lock, data_in,
    input  bus_out, bus_valid, grant, grant_idx, sel_err, lock_timeout
  );

  // Selector side.
  modport slave (
    input  mode, sel, sel_en, req, lock, data_in,
    output bus_out, bus_valid, grant, grant_idx, sel_err, lock_timeout
  );

endinterface

// File: rtl/bus_arbiter_mux_rr_pick.sv
// Combinational round-robin picker: first eligible request at or above ptr,
// wrapping modulo N_SRC. Masked requests are never eligible.
module rr_pick #(
  parameter int N_SRC = 32,
  parameter int SEL_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [N_SRC-1:0] mask,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [N_SRC-1:0] elig;
  logic [SEL_W-1:0] cand;

  assign elig = req & ~mask;

  // (ptr + i) mod N_SRC without relying on N_SRC being a power of two.
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] p, input int i);
    int s;
    s = int'(p) + i;
    if (s >= N_SRC) s = s - N_SRC;
    return SEL_W'(s);
  endfunction

  // Scan from the pointer upward and keep the first eligible source.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      cand = wrap_add(ptr, i);
      if (!found && elig[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Registered bus source selector: DIRECT select or round-robin arbitration
// with bounded locking. The bus is driven one cycle after selection.
module bus_arbiter_mux
  import bus_pkg::*;
#(
  parameter int WIDTH    = BUS_WIDTH,
  parameter int N_SRC    = BUS_N_SRC,
  parameter int MAX_LOCK = BUS_MAX_LOCK
) (
  input  logic              clk,
  input  logic              reset_n,
  bus_arbiter_mux_if.slave  bus
);

  localparam int SEL_W = $clog2(N_SRC);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  mode_e            mode;
  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SEL_W-1:0] grant_idx_q;
  logic             load;
  logic [SEL_W-1:0] win_idx;
  logic [WIDTH-1:0] win_data;
  logic [N_SRC-1:0] grant_d;
  logic             sel_err_d;
  logic             lto_d;

  logic             owner_hold;
  logic             at_limit;
  logic             force_off;
  logic [N_SRC-1:0] pick_mask;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;

  assign mode = mode_e'(bus.mode);

  // While OWNED, grant_idx_q is the owner: it is reloaded every owned cycle.
  assign owner_hold = bus.req[grant_idx_q] & bus.lock[grant_idx_q];
  assign at_limit   = (cnt_q == CNT_W'(MAX_LOCK));
  assign force_off  = (mode == MODE_RR) && (state_q == ST_OWNED) && owner_hold && at_limit;
  // Only the timed-out owner is excluded, and only for this one decision.
  assign pick_mask  = force_off ? (N_SRC'(1) << grant_idx_q) : '0;

  rr_pick #(
    .N_SRC (N_SRC),
    .SEL_W (SEL_W)
  ) u_pick (
    .req   (bus.req),
    .mask  (pick_mask),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Next-state, winner selection and pulse generation.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    win_idx   = grant_idx_q;
    sel_err_d = 1'b0;
    lto_d     = 1'b0;

    if (mode == MODE_DIRECT) begin
      // Leaving RR drops any lock; the pointer is kept for the return.
      state_d = ST_IDLE;
      cnt_d   = '0;
      if (bus.sel_en) begin
        if ({1'b0, bus.sel} < (SEL_W + 1)'(N_SRC)) begin
          load    = 1'b1;
          win_idx = bus.sel;
        end else begin
          sel_err_d = 1'b1;
        end
      end
    end else if (state_q == ST_OWNED && owner_hold && !at_limit) begin
      load    = 1'b1;
      win_idx = grant_idx_q;
      cnt_d   = cnt_q + 1'b1;
    end else begin
      // Fresh arbitration: idle, owner released (no bubble), or owner timed out.
      lto_d = force_off;
      if (pick_found) begin
        load    = 1'b1;
        win_idx = pick_idx;
        ptr_d   = (pick_idx == SEL_W'(N_SRC - 1)) ? '0 : pick_idx + 1'b1;
        if (bus.lock[pick_idx]) begin
          state_d = ST_OWNED;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end else begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end
  end

  // Source data mux for the winning index.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (win_idx == SEL_W'(i)) win_data = bus.data_in[i*WIDTH +: WIDTH];
    end
  end

  assign grant_d = N_SRC'(1) << win_idx;

  // Arbiter state, pointer and lock counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output registers; bus_out and grant_idx hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.bus_out      <= '0;
      bus.bus_valid    <= 1'b0;
      bus.grant        <= '0;
      grant_idx_q      <= '0;
      bus.sel_err      <= 1'b0;
      bus.lock_timeout <= 1'b0;
    end else begin
      bus.sel_err      <= sel_err_d;
      bus.lock_timeout <= lto_d;
      bus.bus_valid    <= load;
      if (load) begin
        bus.bus_out <= win_data;
        bus.grant   <= grant_d;
        grant_idx_q <= win_idx;
      end else begin
        bus.grant   <= '0;
      end
    end
  end

  assign bus.grant_idx = grant_idx_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Scoreboard bench for bus_arbiter_mux: directed stimulus pushes hand-computed
// expected outputs; per-DUT monitors pop and compare once per cycle.
module tb_bus_arbiter_mux;
  import bus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  // A: 32 sources, short lock limit. B: 24 sources, for out-of-range selects.
  bus_arbiter_mux_if #(.WIDTH(32), .N_SRC(32)) ifa ();
  bus_arbiter_mux_if #(.WIDTH(32), .N_SRC(24)) ifb ();

  bus_arbiter_mux #(.WIDTH(32), .N_SRC(32), .MAX_LOCK(4)) dut_a (
    .clk     (clk),
    .reset_n (rst_a),
    .bus     (ifa)
  );

  bus_arbiter_mux #(.WIDTH(32), .N_SRC(24), .MAX_LOCK(16)) dut_b (
    .clk     (clk),
    .reset_n (rst_b),
    .bus     (ifb)
  );

  typedef struct {
    int          id;
    logic [31:0] bus;
    logic        valid;
    logic [31:0] grant;
    logic [4:0]  gidx;
    logic        serr;
    logic        lto;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_id = 0;

  function automatic logic [31:0] src_a(input int i);
    return 32'hC000_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] src_b(input int i);
    return 32'hB000_0000 + 32'(i);
  endfunction

  task automatic check(input string name, input int id, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, want);
    end
  endtask

  task automatic set_a(input logic m, input logic [4:0] s, input logic se,
                       input logic [31:0] r, input logic [31:0] l);
    ifa.mode   = m;
    ifa.sel    = s;
    ifa.sel_en = se;
    ifa.req    = r;
    ifa.lock   = l;
  endtask

  task automatic set_b(input logic [4:0] s, input logic se);
    ifb.mode   = 1'b0;
    ifb.sel    = s;
    ifb.sel_en = se;
    ifb.req    = '0;
    ifb.lock   = '0;
  endtask

  // Inputs are already applied; the expectation is for outputs after the next edge.
  task automatic expect_a(input logic [31:0] b, input logic v, input logic [31:0] g,
                          input logic [4:0] gi, input logic se, input logic lt);
    exp_t e;
    e.id = step_id; e.bus = b; e.valid = v; e.grant = g; e.gidx = gi; e.serr = se; e.lto = lt;
    step_id++;
    @(posedge clk);
    qa.push_back(e);
    #1;
  endtask

  task automatic expect_b(input logic [31:0] b, input logic v, input logic [31:0] g,
                          input logic [4:0] gi, input logic se);
    exp_t e;
    e.id = step_id; e.bus = b; e.valid = v; e.grant = g; e.gidx = gi; e.serr = se; e.lto = 1'b0;
    step_id++;
    @(posedge clk);
    qb.push_back(e);
    #1;
  endtask

  // Monitor for DUT A.
  always @(negedge clk) begin
    if (qa.size() != 0) begin
      ea = qa.pop_front();
      check("a_bus_out",      ea.id, 64'(ifa.bus_out),      64'(ea.bus));
      check("a_bus_valid",    ea.id, 64'(ifa.bus_valid),    64'(ea.valid));
      check("a_grant",        ea.id, 64'(ifa.grant),        64'(ea.grant));
      check("a_grant_idx",    ea.id, 64'(ifa.grant_idx),    64'(ea.gidx));
      check("a_sel_err",      ea.id, 64'(ifa.sel_err),      64'(ea.serr));
      check("a_lock_timeout", ea.id, 64'(ifa.lock_timeout), 64'(ea.lto));
    end
  end

  // Monitor for DUT B.
  always @(negedge clk) begin
    if (qb.size() != 0) begin
      eb = qb.pop_front();
      check("b_bus_out",      eb.id, 64'(ifb.bus_out),      64'(eb.bus));
      check("b_bus_valid",    eb.id, 64'(ifb.bus_valid),    64'(eb.valid));
      check("b_grant",        eb.id, 64'(ifb.grant),        64'(eb.grant));
      check("b_grant_idx",    eb.id, 64'(ifb.grant_idx),    64'(eb.gidx));
      check("b_sel_err",      eb.id, 64'(ifb.sel_err),      64'(eb.serr));
      check("b_lock_timeout", eb.id, 64'(ifb.lock_timeout), 64'(eb.lto));
    end
  end

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    set_a(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    set_b(5'd0, 1'b0);
    for (int i = 0; i < 32; i++) ifa.data_in[i*32 +: 32] = src_a(i);
    for (int i = 0; i < 24; i++) ifb.data_in[i*32 +: 32] = src_b(i);

    // Reset state, then idle with nothing selected.
    expect_a(32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    expect_a(32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    rst_a = 1'b1;
    expect_a(32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);

    // DIRECT load of source 5, hold, then req/lock ignored in DIRECT.
    ifa.data_in[5*32 +: 32] = 32'hDEAD_BEEF;
    set_a(1'b0, 5'd5, 1'b1, 32'h0, 32'h0);
    expect_a(32'hDEAD_BEEF, 1'b1, 32'h1 << 5, 5'd5, 1'b0, 1'b0);
    set_a(1'b0, 5'd5, 1'b0, 32'h0, 32'h0);
    expect_a(32'hDEAD_BEEF, 1'b0, 32'h0, 5'd5, 1'b0, 1'b0);
    set_a(1'b0, 5'd1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_a(src_a(1), 1'b1, 32'h2, 5'd1, 1'b0, 1'b0);

    // Reset mid-stream wins over a valid select.
    rst_a = 1'b0;
    set_a(1'b0, 5'd7, 1'b1, 32'h0, 32'h0);
    expect_a(32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    rst_a = 1'b1;

    // Round-robin fairness over sources {2,7,30}.
    set_a(1'b1, 5'd0, 1'b0, 32'h4000_0084, 32'h0);
    expect_a(src_a(2),  1'b1, 32'h1 << 2,  5'd2,  1'b0, 1'b0);
    expect_a(src_a(7),  1'b1, 32'h1 << 7,  5'd7,  1'b0, 1'b0);
    expect_a(src_a(30), 1'b1, 32'h1 << 30, 5'd30, 1'b0, 1'b0);
    expect_a(src_a(2),  1'b1, 32'h1 << 2,  5'd2,  1'b0, 1'b0);
    expect_a(src_a(7),  1'b1, 32'h1 << 7,  5'd7,  1'b0, 1'b0);

    // Lock and timeout: source 3 locked, source 9 waiting.
    rst_a = 1'b0;
    set_a(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    expect_a(32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    rst_a = 1'b1;
    set_a(1'b1, 5'd0, 1'b0, 32'h0000_0208, 32'h0000_0008);
    for (int i = 0; i < 4; i++) expect_a(src_a(3), 1'b1, 32'h8, 5'd3, 1'b0, 1'b0);
    expect_a(src_a(9), 1'b1, 32'h200, 5'd9, 1'b0, 1'b1);
    expect_a(src_a(3), 1'b1, 32'h8,   5'd3, 1'b0, 1'b0);

    // Timeout with no other requester: one empty cycle, then the owner again.
    set_a(1'b1, 5'd0, 1'b0, 32'h0000_0008, 32'h0000_0008);
    for (int i = 0; i < 3; i++) expect_a(src_a(3), 1'b1, 32'h8, 5'd3, 1'b0, 1'b0);
    expect_a(src_a(3), 1'b0, 32'h0, 5'd3, 1'b0, 1'b1);
    expect_a(src_a(3), 1'b1, 32'h8, 5'd3, 1'b0, 1'b0);

    // Early release: no bubble between owner 3 and source 9.
    rst_a = 1'b0;
    set_a(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    expect_a(32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    rst_a = 1'b1;
    set_a(1'b1, 5'd0, 1'b0, 32'h0000_0208, 32'h0000_0008);
    expect_a(src_a(3), 1'b1, 32'h8, 5'd3, 1'b0, 1'b0);
    expect_a(src_a(3), 1'b1, 32'h8, 5'd3, 1'b0, 1'b0);
    set_a(1'b1, 5'd0, 1'b0, 32'h0000_0208, 32'h0);
    expect_a(src_a(9), 1'b1, 32'h200, 5'd9, 1'b0, 1'b0);

    // Single requester without lock is granted every cycle.
    set_a(1'b1, 5'd0, 1'b0, 32'h0000_0200, 32'h0);
    expect_a(src_a(9), 1'b1, 32'h200, 5'd9, 1'b0, 1'b0);
    expect_a(src_a(9), 1'b1, 32'h200, 5'd9, 1'b0, 1'b0);

    // Mode switch while source 3 owns the bus; pointer (4) survives.
    set_a(1'b1, 5'd0, 1'b0, 32'h0000_0008, 32'h0000_0008);
    expect_a(src_a(3), 1'b1, 32'h8, 5'd3, 1'b0, 1'b0);
    expect_a(src_a(3), 1'b1, 32'h8, 5'd3, 1'b0, 1'b0);
    set_a(1'b0, 5'd1, 1'b1, 32'h0000_0008, 32'h0000_0008);
    expect_a(src_a(1), 1'b1, 32'h2, 5'd1, 1'b0, 1'b0);
    set_a(1'b1, 5'd0, 1'b0, 32'h0000_0208, 32'h0);
    expect_a(src_a(9), 1'b1, 32'h200, 5'd9, 1'b0, 1'b0);

    // Reset while locked.
    set_a(1'b1, 5'd0, 1'b0, 32'h0000_0008, 32'h0000_0008);
    expect_a(src_a(3), 1'b1, 32'h8, 5'd3, 1'b0, 1'b0);
    rst_a = 1'b0;
    expect_a(32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);

    // DUT B: out-of-range DIRECT selects with 24 sources.
    expect_b(32'h0, 1'b0, 32'h0, 5'd0, 1'b0);
    rst_b = 1'b1;
    set_b(5'd4, 1'b1);
    expect_b(src_b(4), 1'b1, 32'h10, 5'd4, 1'b0);
    set_b(5'd27, 1'b1);
    expect_b(src_b(4), 1'b0, 32'h0, 5'd4, 1'b1);
    set_b(5'd27, 1'b0);
    expect_b(src_b(4), 1'b0, 32'h0, 5'd4, 1'b0);
    set_b(5'd23, 1'b1);
    expect_b(src_b(23), 1'b1, 32'h1 << 23, 5'd23, 1'b0);
    set_b(5'd24, 1'b1);
    expect_b(src_b(23), 1'b0, 32'h0, 5'd23, 1'b1);
    set_b(5'd0, 1'b0);
    expect_b(src_b(23), 1'b0, 32'h0, 5'd23, 1'b0);

    // Every expectation must have been consumed by a monitor.
    @(negedge clk);
    #1;
    check("queue_drain", -1, 64'(qa.size() + qb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
